// File: rtl/conv_write_master_if.sv
// Handshake bundles for conv_write_master: the write-buffer req/ack line port
// and the single-beat Avalon-MM write master port.
interface wbuf_if;
   logic [511:0] WriteBuffer_i;
   logic         WriteReq_i;
   logic         WriteAck_o;
   logic         First_i;
   logic         Last_i;

   modport master (output WriteBuffer_i, WriteReq_i, First_i, Last_i, input WriteAck_o);
   modport slave  (input WriteBuffer_i, WriteReq_i, First_i, Last_i, output WriteAck_o);
endinterface

interface avm_if #(parameter int ADDR_WIDTH = 32);
   logic [ADDR_WIDTH-1:0] avm_address;
   logic                  avm_write;
   logic [511:0]          avm_writedata;
   logic [63:0]           avm_byteenable;
   logic                  avm_waitrequest;

   modport master (output avm_address, avm_write, avm_writedata, avm_byteenable,
                   input avm_waitrequest);
   modport slave  (input avm_address, avm_write, avm_writedata, avm_byteenable,
                   output avm_waitrequest);
endinterface

// File: rtl/conv_write_master.sv
// Queues 512-bit result lines from the convolution write buffer and issues them as
// single-beat Avalon-MM writes at consecutive 64-byte addresses from a frame base.
module conv_write_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   wbuf_if.slave                 wbuf,
   avm_if.master                 avm,
   input  logic [ADDR_WIDTH-1:0] DstAddr_i,
   output logic                  Busy_o,
   output logic                  Done_o,
   output logic [15:0]           BeatCount_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef struct packed {
      logic         last;
      logic         first;
      logic [511:0] data;
   } line_t;

   line_t                 mem [FIFO_DEPTH];
   logic [PTR_W:0]        wr_ptr;
   logic [PTR_W:0]        rd_ptr;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;
   line_t                 head;
   logic [ADDR_WIDTH-1:0] frame_base;
   logic [ADDR_WIDTH-1:0] next_addr;
   logic [ADDR_WIDTH-1:0] issue_addr;

   // Full is judged on the pre-pop occupancy, so a full queue never acks even while draining.
   assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                  (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign push  = wbuf.WriteReq_i & ~full;
   assign pop   = ~empty & ~avm.avm_waitrequest;

   assign head       = mem[rd_ptr[PTR_W-1:0]];
   assign frame_base = DstAddr_i & ~ADDR_WIDTH'(63);
   assign issue_addr = head.first ? frame_base : next_addr;

   assign wbuf.WriteAck_o    = push;
   assign avm.avm_write      = ~empty;
   assign avm.avm_writedata  = head.data;
   assign avm.avm_address    = issue_addr;
   assign avm.avm_byteenable = '1;
   assign Busy_o             = ~empty;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: line storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[PTR_W-1:0]] <= '{last: wbuf.Last_i, first: wbuf.First_i,
                                             data: wbuf.WriteBuffer_i};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         next_addr   <= '0;
         BeatCount_o <= '0;
         Done_o      <= 1'b0;
      end else begin
         Done_o <= pop & head.last;
         if (pop) begin
            next_addr   <= issue_addr + ADDR_WIDTH'(64);
            BeatCount_o <= head.first ? 16'd1 : BeatCount_o + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_conv_write_master.sv
// Scoreboard bench for conv_write_master: acked lines are queued with their flags,
// and a monitor checks each issued write against a frame-base + 64*index model.
module tb_conv_write_master;

   localparam int DEPTH = 4;
   localparam int AW    = 32;

   typedef struct {
      logic [511:0] data;
      logic         first;
      logic         last;
   } line_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [AW-1:0] dst_addr;
   logic          busy;
   logic          done;
   logic [15:0]   beat_count;

   wbuf_if                      wb ();
   avm_if #(.ADDR_WIDTH(AW))    avm ();

   conv_write_master #(.FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .wbuf        (wb.slave),
      .avm         (avm.master),
      .DstAddr_i   (dst_addr),
      .Busy_o      (busy),
      .Done_o      (done),
      .BeatCount_o (beat_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   line_t         sbq[$];
   logic [AW-1:0] addr_log[$];
   int            done_seen = 0;
   int            ack_count = 0;
   logic          rand_mode = 1'b0;

   // Reference model: address = frame base + 64 * line index within the frame.
   logic [AW-1:0] m_base = '0;
   int unsigned   m_idx = 0;
   logic [15:0]   exp_beat = '0;
   logic          exp_done = 1'b0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Monitor: samples on the falling edge, pops the scoreboard on each accepted write.
   initial begin
      line_t         e;
      logic [AW-1:0] exp_addr;
      forever begin
         @(negedge clk);
         if (!rstn) continue;
         if (done) done_seen++;
         check("done", done, exp_done);
         check("beat_count", beat_count, exp_beat);
         check("avm_write", avm.avm_write, sbq.size() != 0);
         check("busy", busy, sbq.size() != 0);
         check("ack", wb.WriteAck_o, wb.WriteReq_i && (sbq.size() < DEPTH));
         exp_done = 1'b0;
         if (avm.avm_write && sbq.size() != 0) begin
            e = sbq[0];
            exp_addr = e.first ? (dst_addr & ~AW'(63)) : m_base + AW'(m_idx << 6);
            check("address", avm.avm_address, exp_addr);
            check("writedata", avm.avm_writedata, e.data);
            check("byteenable", avm.avm_byteenable, {64{1'b1}});
            if (!avm.avm_waitrequest) begin
               void'(sbq.pop_front());
               if (e.first) begin
                  m_base   = dst_addr & ~AW'(63);
                  m_idx    = 0;
                  exp_beat = '0;
               end
               addr_log.push_back(exp_addr);
               m_idx++;
               exp_beat = exp_beat + 16'd1;
               exp_done = e.last;
            end
         end
      end
   end

   // Random stall / base-address noise, enabled only for the randomized phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_mode) begin
            avm.avm_waitrequest = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) dst_addr = $urandom;
         end
      end
   end

   task automatic send_line(input logic [511:0] d, input logic f, input logic l);
      logic got;
      wb.WriteBuffer_i = d;
      wb.First_i       = f;
      wb.Last_i        = l;
      wb.WriteReq_i    = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 400 && !got; n++) begin
         @(negedge clk);
         #1;
         if (wb.WriteAck_o) got = 1'b1;
      end
      if (got) begin
         sbq.push_back('{data: d, first: f, last: l});
         ack_count++;
      end else begin
         checks++;
         errors++;
         $display("FAIL ack_timeout: got no ack expected ack within 400 cycles");
      end
      @(posedge clk);
      #1;
      wb.WriteReq_i = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || avm.avm_write) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", n < 2000, 1'b1);
      repeat (3) @(negedge clk);
   endtask

   task automatic start_case(input logic [AW-1:0] base);
      @(posedge clk);
      #1;
      dst_addr = base;
      addr_log.delete();
      done_seen = 0;
   endtask

   initial begin
      logic [AW-1:0] exp_t1 [4];
      int            acks0;
      exp_t1 = '{32'h2000_0040, 32'h2000_0080, 32'h2000_00C0, 32'h2000_0100};

      wb.WriteBuffer_i    = '0;
      wb.WriteReq_i       = 1'b0;
      wb.First_i          = 1'b0;
      wb.Last_i           = 1'b0;
      avm.avm_waitrequest = 1'b0;
      dst_addr            = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_avm_write", avm.avm_write, 1'b0);
      check("rst_ack", wb.WriteAck_o, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_beat", beat_count, 16'd0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Non-First line straight after reset lands at address 0.
      start_case(32'h7777_7777);
      send_line(rand_line(), 1'b0, 1'b0);
      wait_drain();
      check("nofirst_addr", addr_log[0], 32'h0);
      check("nofirst_beat", beat_count, 16'd1);

      // Four-line frame at 0x2000_0040.
      start_case(32'h2000_0040);
      send_line(rand_line(), 1'b1, 1'b0);
      send_line(rand_line(), 1'b0, 1'b0);
      send_line(rand_line(), 1'b0, 1'b0);
      send_line(rand_line(), 1'b0, 1'b1);
      wait_drain();
      check("t1_count", addr_log.size(), 4);
      for (int i = 0; i < 4; i++) check("t1_addr", addr_log[i], exp_t1[i]);
      check("t1_beat", beat_count, 16'd4);
      check("t1_done_pulses", done_seen, 1);

      // Stall for 20 cycles while six lines are offered.
      start_case(32'h3000_0000);
      avm.avm_waitrequest = 1'b1;
      acks0 = ack_count;
      fork
         begin
            for (int i = 0; i < 6; i++) send_line(rand_line(), i == 0, i == 5);
         end
         begin
            repeat (20) @(negedge clk);
            #2;
            check("stall_acks", ack_count - acks0, DEPTH);
            check("stall_req_held", wb.WriteReq_i, 1'b1);
            check("stall_no_ack", wb.WriteAck_o, 1'b0);
            check("stall_busy", busy, 1'b1);
            @(posedge clk);
            #1;
            avm.avm_waitrequest = 1'b0;
         end
      join
      wait_drain();
      check("stall_count", addr_log.size(), 6);
      check("stall_beat", beat_count, 16'd6);
      check("stall_done_pulses", done_seen, 1);

      // Single line carrying both First and Last, unaligned base.
      start_case(32'h1000_003F);
      send_line(rand_line(), 1'b1, 1'b1);
      wait_drain();
      check("fl_addr", addr_log[0], 32'h1000_0000);
      check("fl_beat", beat_count, 16'd1);
      check("fl_done_pulses", done_seen, 1);

      // Back-to-back frames queued behind one another.
      start_case(32'h4000_0000);
      avm.avm_waitrequest = 1'b1;
      send_line(rand_line(), 1'b1, 1'b0);
      send_line(rand_line(), 1'b0, 1'b1);
      send_line(rand_line(), 1'b1, 1'b0);
      send_line(rand_line(), 1'b0, 1'b1);
      @(posedge clk);
      #1;
      avm.avm_waitrequest = 1'b0;
      wait_drain();
      check("b2b_addr2", addr_log[2], 32'h4000_0000);
      check("b2b_addr3", addr_log[3], 32'h4000_0040);
      check("b2b_done_pulses", done_seen, 2);

      // Reset while three lines are stalled in the queue.
      start_case(32'h6000_0000);
      avm.avm_waitrequest = 1'b1;
      send_line(rand_line(), 1'b1, 1'b0);
      send_line(rand_line(), 1'b0, 1'b0);
      send_line(rand_line(), 1'b0, 1'b0);
      #2;
      rstn = 1'b0;
      #1;
      check("midrst_avm_write", avm.avm_write, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_beat", beat_count, 16'd0);
      sbq.delete();
      m_base   = '0;
      m_idx    = 0;
      exp_beat = '0;
      exp_done = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
      avm.avm_waitrequest = 1'b0;
      start_case(32'h5000_0100);
      send_line(rand_line(), 1'b1, 1'b0);
      send_line(rand_line(), 1'b0, 1'b1);
      wait_drain();
      check("postrst_count", addr_log.size(), 2);
      check("postrst_addr0", addr_log[0], 32'h5000_0100);
      check("postrst_addr1", addr_log[1], 32'h5000_0140);

      // Address wrap at the top of the space.
      start_case(32'hFFFF_FFC0);
      send_line(rand_line(), 1'b1, 1'b0);
      send_line(rand_line(), 1'b0, 1'b1);
      wait_drain();
      check("wrap_addr0", addr_log[0], 32'hFFFF_FFC0);
      check("wrap_addr1", addr_log[1], 32'h0000_0000);

      // Randomized traffic: random flags, stalls and base-address changes.
      start_case(32'h0);
      rand_mode = 1'b1;
      for (int i = 0; i < 60; i++)
         send_line(rand_line(), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      rand_mode = 1'b0;
      @(posedge clk);
      #1;
      avm.avm_waitrequest = 1'b0;
      wait_drain();
      check("rand_count", addr_log.size(), 60);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
